// File: rtl/instruction_fetcher.sv
// instruction_fetcher: issues one program-memory read per FETCH and holds the returned word for decode
module instruction_fetcher #(
  parameter int PROGRAM_MEM_ADDR_BITS = 8,
  parameter int PROGRAM_MEM_DATA_BITS = 16,
  parameter int CYCLE_COUNT_BITS = 8
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             enable,
  input  logic [2:0]                       core_state,
  input  logic [PROGRAM_MEM_ADDR_BITS-1:0] current_pc,
  output logic                             mem_read_valid,
  output logic [PROGRAM_MEM_ADDR_BITS-1:0] mem_read_address,
  input  logic                             mem_read_ready,
  input  logic [PROGRAM_MEM_DATA_BITS-1:0] mem_read_data,
  output logic [2:0]                       fetcher_state,
  output logic [PROGRAM_MEM_DATA_BITS-1:0] instruction,
  output logic [CYCLE_COUNT_BITS-1:0]      fetch_cycles
);
  typedef enum logic [2:0] {IDLE = 3'b000, FETCHING = 3'b001, FETCHED = 3'b010} state_t;
  localparam logic [2:0] CORE_FETCH = 3'b001;
  localparam logic [2:0] CORE_DECODE = 3'b010;
  state_t                           state_q;
  logic                             valid_q;
  logic [PROGRAM_MEM_ADDR_BITS-1:0] addr_q;
  logic [PROGRAM_MEM_DATA_BITS-1:0] instr_q;
  logic [CYCLE_COUNT_BITS-1:0]      cycles_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      valid_q  <= 1'b0;
      addr_q   <= '0;
      instr_q  <= '0;
      cycles_q <= '0;
    end else begin
      case (state_q)
        IDLE: if (enable && core_state == CORE_FETCH) begin
          state_q  <= FETCHING;
          valid_q  <= 1'b1;
          addr_q   <= current_pc;
          cycles_q <= '0;
        end
        FETCHING: begin
          // the completing cycle is counted too; saturate rather than wrap
          cycles_q <= cycles_q + CYCLE_COUNT_BITS'(cycles_q != '1);
          if (mem_read_ready) begin
            instr_q <= mem_read_data;
            valid_q <= 1'b0;
            state_q <= FETCHED;
          end
        end
        FETCHED: if (core_state == CORE_DECODE) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end
  assign fetcher_state    = state_q;
  assign mem_read_valid   = valid_q;
  assign mem_read_address = addr_q;
  assign instruction      = instr_q;
  assign fetch_cycles     = cycles_q;
endmodule

// File: tb/tb_instruction_fetcher.sv
// tb_instruction_fetcher: directed checks of fetch handshake, address hold, gating, saturation and async reset
module tb_instruction_fetcher;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic [2:0]  core_state = 3'b000;
  logic [7:0]  current_pc = 8'h00;
  logic        mem_read_valid;
  logic [7:0]  mem_read_address;
  logic        mem_read_ready = 1'b0;
  logic [15:0] mem_read_data = 16'h0000;
  logic [2:0]  fetcher_state;
  logic [15:0] instruction;
  logic [7:0]  fetch_cycles;
  int checks = 0;
  int errors = 0;
  int valid_hi;
  instruction_fetcher dut (
    .clk(clk),
    .reset(reset),
    .enable(enable),
    .core_state(core_state),
    .current_pc(current_pc),
    .mem_read_valid(mem_read_valid),
    .mem_read_address(mem_read_address),
    .mem_read_ready(mem_read_ready),
    .mem_read_data(mem_read_data),
    .fetcher_state(fetcher_state),
    .instruction(instruction),
    .fetch_cycles(fetch_cycles)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic all_zero(input string tag);
    chk({tag, "_state"}, 32'(fetcher_state), 32'h0);
    chk({tag, "_valid"}, 32'(mem_read_valid), 32'h0);
    chk({tag, "_addr"}, 32'(mem_read_address), 32'h0);
    chk({tag, "_instr"}, 32'(instruction), 32'h0);
    chk({tag, "_cycles"}, 32'(fetch_cycles), 32'h0);
  endtask
  initial begin
    tick();
    tick();
    all_zero("reset");
    reset = 1'b0;
    // single fetch, ready on the third valid cycle
    enable = 1'b1; core_state = 3'b001; current_pc = 8'h2A;
    valid_hi = 0;
    tick();
    chk("f1_state", 32'(fetcher_state), 32'h1);
    chk("f1_addr", 32'(mem_read_address), 32'h2A);
    chk("f1_cyc0", 32'(fetch_cycles), 32'h0);
    core_state = 3'b010;
    valid_hi += int'(mem_read_valid);
    tick();
    valid_hi += int'(mem_read_valid);
    tick();
    valid_hi += int'(mem_read_valid);
    mem_read_ready = 1'b1; mem_read_data = 16'h9C41;
    tick();
    valid_hi += int'(mem_read_valid);
    mem_read_ready = 1'b0;
    chk("f1_valid_cycles", 32'(valid_hi), 32'd3);
    chk("f1_done_state", 32'(fetcher_state), 32'h2);
    chk("f1_instr", 32'(instruction), 32'h9C41);
    chk("f1_cycles", 32'(fetch_cycles), 32'd3);
    tick();
    chk("f1_idle", 32'(fetcher_state), 32'h0);
    chk("f1_instr_held", 32'(instruction), 32'h9C41);
    // address stability while current_pc moves
    core_state = 3'b001; current_pc = 8'h10;
    tick();
    core_state = 3'b000; current_pc = 8'h55;
    tick();
    chk("addr_hold1", 32'(mem_read_address), 32'h10);
    tick();
    chk("addr_hold2", 32'(mem_read_address), 32'h10);
    mem_read_ready = 1'b1; mem_read_data = 16'h1234;
    tick();
    mem_read_ready = 1'b0;
    chk("addr_done_state", 32'(fetcher_state), 32'h2);
    chk("addr_instr", 32'(instruction), 32'h1234);
    chk("addr_cycles", 32'(fetch_cycles), 32'd3);
    core_state = 3'b010;
    tick();
    chk("addr_idle", 32'(fetcher_state), 32'h0);
    // enable gating
    enable = 1'b0; core_state = 3'b001;
    valid_hi = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      valid_hi += int'(mem_read_valid);
    end
    chk("gate_no_valid", 32'(valid_hi), 32'd0);
    chk("gate_state", 32'(fetcher_state), 32'h0);
    enable = 1'b1; current_pc = 8'h3C;
    tick();
    chk("gate_start", 32'(mem_read_valid), 32'h1);
    enable = 1'b0;
    tick();
    tick();
    chk("gate_still_valid", 32'(mem_read_valid), 32'h1);
    mem_read_ready = 1'b1; mem_read_data = 16'hABCD;
    tick();
    mem_read_ready = 1'b0;
    chk("gate_state_done", 32'(fetcher_state), 32'h2);
    chk("gate_instr", 32'(instruction), 32'hABCD);
    chk("gate_cycles", 32'(fetch_cycles), 32'd3);
    // spurious ready while FETCHED, then while IDLE
    mem_read_ready = 1'b1; mem_read_data = 16'hFFFF;
    tick();
    mem_read_ready = 1'b0;
    chk("spur_fetched_state", 32'(fetcher_state), 32'h2);
    chk("spur_fetched_instr", 32'(instruction), 32'hABCD);
    core_state = 3'b010;
    tick();
    chk("spur_to_idle", 32'(fetcher_state), 32'h0);
    mem_read_ready = 1'b1;
    tick();
    mem_read_ready = 1'b0;
    chk("spur_idle_state", 32'(fetcher_state), 32'h0);
    chk("spur_idle_valid", 32'(mem_read_valid), 32'h0);
    chk("spur_idle_instr", 32'(instruction), 32'hABCD);
    // saturation
    enable = 1'b1; core_state = 3'b001; current_pc = 8'h99;
    tick();
    core_state = 3'b000;
    for (int i = 0; i < 300; i++) tick();
    chk("sat_cycles", 32'(fetch_cycles), 32'hFF);
    chk("sat_state", 32'(fetcher_state), 32'h1);
    chk("sat_valid", 32'(mem_read_valid), 32'h1);
    // asynchronous reset mid-cycle
    #2 reset = 1'b1;
    #1;
    all_zero("async_rst");
    tick();
    reset = 1'b0;
    mem_read_ready = 1'b1; mem_read_data = 16'hFFFF;
    tick();
    mem_read_ready = 1'b0;
    chk("post_rst_state", 32'(fetcher_state), 32'h0);
    chk("post_rst_instr", 32'(instruction), 32'h0);
    // next fetch after reset, ready on first cycle
    core_state = 3'b001; current_pc = 8'h77;
    tick();
    chk("refetch_addr", 32'(mem_read_address), 32'h77);
    chk("refetch_valid", 32'(mem_read_valid), 32'h1);
    core_state = 3'b000;
    mem_read_ready = 1'b1; mem_read_data = 16'h5A5A;
    tick();
    mem_read_ready = 1'b0;
    chk("refetch_state", 32'(fetcher_state), 32'h2);
    chk("refetch_instr", 32'(instruction), 32'h5A5A);
    chk("refetch_cycles", 32'(fetch_cycles), 32'd1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
